// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main control FSM.
// Sequences fetch / decode / execute / memory / write-back and drives the
// datapath selects and enables. Control outputs are Moore decodes of the
// state, except that FETCH gates ir_write and pc_write with mem_ready.
// All outputs are held at 0 while rst is high, including FETCH's mem_read.
module mips_mc_ctrl #(
    parameter int unsigned OP_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic [3:0]          state
);

    // Supported opcodes (IR[31:26])
    localparam logic [OP_WIDTH-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_WIDTH-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_WIDTH-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_WIDTH-1:0] OP_J     = 6'b000010;
    localparam logic [OP_WIDTH-1:0] OP_ADDI  = 6'b001000;

    // ALU source B selects
    localparam logic [1:0] SRC_B_REG   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_IMMSH = 2'b11;

    // ALU operation selects
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // PC source selects
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EX   = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   illegal_op_q;
    logic   illegal_op_d;

    // State and illegal-opcode flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    // Next-state logic; opcode is only consulted in DECODE and MEM_ADDR
    always_comb begin
        state_d      = FETCH;
        illegal_op_d = 1'b0;
        case (state_q)
            FETCH: begin
                state_d = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EX;
                    default: begin
                        state_d      = FETCH;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                // An opcode that changed illegally since DECODE falls back to FETCH
                if (opcode == OP_LW) begin
                    state_d = MEM_READ;
                end else if (opcode == OP_SW) begin
                    state_d = MEM_WRITE;
                end else begin
                    state_d = FETCH;
                end
            end
            MEM_READ: begin
                state_d = mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                state_d = FETCH;
            end
            MEM_WRITE: begin
                state_d = mem_ready ? FETCH : MEM_WRITE;
            end
            EXECUTE: begin
                state_d = R_WB;
            end
            R_WB: begin
                state_d = FETCH;
            end
            BRANCH: begin
                state_d = FETCH;
            end
            JUMP: begin
                state_d = FETCH;
            end
            ADDI_EX: begin
                state_d = ADDI_WB;
            end
            ADDI_WB: begin
                state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Control output decode; rst forces everything low without waiting for a clock
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCS_ALU;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    i_or_d    = 1'b0;
                    alu_src_a = 1'b0;
                    alu_src_b = SRC_B_FOUR;
                    alu_op    = ALU_ADD;
                    pc_source = PCS_ALU;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_a = 1'b0;
                    alu_src_b = SRC_B_IMMSH;
                    alu_op    = ALU_ADD;
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_ADD;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    reg_dst    = 1'b0;
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_REG;
                    alu_op    = ALU_FUNCT;
                end
                R_WB: begin
                    reg_dst    = 1'b1;
                    mem_to_reg = 1'b0;
                    reg_write  = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_src_b     = SRC_B_REG;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCS_ALUOUT;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCS_JUMP;
                end
                ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_ADD;
                end
                ADDI_WB: begin
                    reg_dst    = 1'b0;
                    mem_to_reg = 1'b0;
                    reg_write  = 1'b1;
                end
                default: begin
                    pc_write = 1'b0;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class cycle by
// cycle and compares state, the full control vector and illegal_op against
// hand-written per-state expectations.
module tb_mips_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    int n_checks;
    int n_pass;

    mips_mc_ctrl #(.OP_WIDTH(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    // {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rwr, asa, asb[1:0], aop[1:0], pcs[1:0]}
    logic [15:0] ctrl_vec;
    assign ctrl_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                       alu_src_b, alu_op, pc_source};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected control vector per state, written out from the state table
    function automatic logic [15:0] exp_ctrl(input int st, input logic mr);
        case (st)
            0:  exp_ctrl = {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
            1:  exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
            2:  exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00};
            3:  exp_ctrl = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
            4:  exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
            5:  exp_ctrl = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
            6:  exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00};
            7:  exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
            8:  exp_ctrl = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01};
            9:  exp_ctrl = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10};
            10: exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00};
            11: exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
            default: exp_ctrl = '0;
        endcase
    endfunction

    // One clock cycle: called at a falling edge, drives mem_ready, checks, moves to next falling edge
    task automatic cyc(input string tag, input int exp_st, input logic mr, input logic exp_ill);
        mem_ready = mr;
        #1;
        check({tag, ".state"}, 32'(state), 32'(exp_st));
        check({tag, ".ctrl"}, 32'(ctrl_vec), 32'(exp_ctrl(exp_st, mr)));
        check({tag, ".illegal"}, 32'(illegal_op), 32'(exp_ill));
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        opcode    = 6'b000000;
        mem_ready = 1'b1;

        // Reset: FETCH encoding but every output held low, including mem_read
        @(negedge clk);
        @(negedge clk);
        check("reset.state", 32'(state), 32'd0);
        check("reset.ctrl", 32'(ctrl_vec), 32'd0);
        check("reset.illegal", 32'(illegal_op), 32'd0);
        rst = 1'b0;

        // R-type 0,1,6,7; opcode changed during EXECUTE must be ignored
        opcode = 6'b000000;
        cyc("rtype.f", 0, 1'b1, 1'b0);
        cyc("rtype.d", 1, 1'b1, 1'b0);
        opcode = 6'b100011;
        cyc("rtype.ex", 6, 1'b1, 1'b0);
        cyc("rtype.wb", 7, 1'b1, 1'b0);

        // lw with 2 FETCH waits and 3 MEM_READ waits; mem_ready ignored elsewhere
        opcode = 6'b100011;
        cyc("lw.f0", 0, 1'b0, 1'b0);
        cyc("lw.f1", 0, 1'b0, 1'b0);
        cyc("lw.f2", 0, 1'b1, 1'b0);
        cyc("lw.d", 1, 1'b0, 1'b0);
        cyc("lw.ma", 2, 1'b0, 1'b0);
        cyc("lw.mr0", 3, 1'b0, 1'b0);
        cyc("lw.mr1", 3, 1'b0, 1'b0);
        cyc("lw.mr2", 3, 1'b0, 1'b0);
        cyc("lw.mr3", 3, 1'b1, 1'b0);
        cyc("lw.wb", 4, 1'b0, 1'b0);

        // sw: 0,1,2,5; mem_ready low in MEM_ADDR has no effect
        opcode = 6'b101011;
        cyc("sw.f", 0, 1'b1, 1'b0);
        cyc("sw.d", 1, 1'b1, 1'b0);
        cyc("sw.ma", 2, 1'b0, 1'b0);
        cyc("sw.mw", 5, 1'b1, 1'b0);

        // beq then j
        opcode = 6'b000100;
        cyc("beq.f", 0, 1'b1, 1'b0);
        cyc("beq.d", 1, 1'b1, 1'b0);
        cyc("beq.br", 8, 1'b1, 1'b0);
        opcode = 6'b000010;
        cyc("j.f", 0, 1'b1, 1'b0);
        cyc("j.d", 1, 1'b1, 1'b0);
        cyc("j.jmp", 9, 1'b1, 1'b0);

        // Illegal opcode: pulse only in the FETCH right after its DECODE
        opcode = 6'b111111;
        cyc("ill.f", 0, 1'b1, 1'b0);
        cyc("ill.d", 1, 1'b1, 1'b0);
        opcode = 6'b100011;
        cyc("ill.f2", 0, 1'b1, 1'b1);
        cyc("lw2.d", 1, 1'b1, 1'b0);
        cyc("lw2.ma", 2, 1'b1, 1'b0);
        cyc("lw2.mr", 3, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle while stalled in MEM_READ
        mem_ready = 1'b0;
        #1;
        check("arst.pre_state", 32'(state), 32'd3);
        #1;
        rst = 1'b1;
        #1;
        check("arst.state", 32'(state), 32'd0);
        check("arst.ctrl", 32'(ctrl_vec), 32'd0);
        check("arst.illegal", 32'(illegal_op), 32'd0);
        @(negedge clk);
        check("arst.hold_ctrl", 32'(ctrl_vec), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // addi after release: 0,1,10,11,0
        opcode = 6'b001000;
        cyc("addi.f", 0, 1'b1, 1'b0);
        cyc("addi.d", 1, 1'b1, 1'b0);
        cyc("addi.ex", 10, 1'b1, 1'b0);
        cyc("addi.wb", 11, 1'b1, 1'b0);
        cyc("addi.f2", 0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
